// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU definitions: op encodings, FSM states and default latencies.
// The Control decoder that produces E_MDU_op imports this package too.
package mdu_defs;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int DEF_MULT_LAT = 5;
    localparam int DEF_DIV_LAT  = 10;
    localparam int DEF_CNT_W    = 4;

    function automatic logic is_start_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_arith.sv
// Combinational MDU arithmetic: 64-bit products and 32-bit quotient/remainder,
// kept apart from the sequencing FSM so the FSM only latches results.
module mdu_arith
    import mdu_defs::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div0
);

    logic signed [63:0] sprod;
    logic        [63:0] uprod;
    logic               sdiv;
    logic        [31:0] abs_a;
    logic        [31:0] abs_b;
    logic        [31:0] div_b;
    logic        [31:0] quot;
    logic        [31:0] rem;

    // Signed divide runs on magnitudes, so 0x80000000 / -1 yields 0x80000000
    // without hitting the two's-complement overflow of a native signed divide.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        res_hi = 32'd0;
        res_lo = 32'd0;
        div0   = 1'b0;

        sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        uprod = {32'd0, a} * {32'd0, b};

        sdiv  = (op == MDU_DIV);
        abs_a = (sdiv && a[31]) ? (32'd0 - a) : a;
        abs_b = (sdiv && b[31]) ? (32'd0 - b) : b;
        div_b = (b == 32'd0) ? 32'd1 : abs_b;
        quot  = abs_a / div_b;
        rem   = abs_a % div_b;

        case (op)
            MDU_MULT: begin
                res_hi = sprod[63:32];
                res_lo = sprod[31:0];
            end
            MDU_MULTU: begin
                res_hi = uprod[63:32];
                res_lo = uprod[31:0];
            end
            MDU_DIV: begin
                res_lo = (a[31] ^ b[31]) ? (32'd0 - quot) : quot;
                res_hi = a[31] ? (32'd0 - rem) : rem;
                div0   = (b == 32'd0);
            end
            MDU_DIVU: begin
                res_lo = quot;
                res_hi = rem;
                div0   = (b == 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// EX-stage MDU sequencer: models multiply/divide latency with a busy counter,
// owns HI/LO, and raises the D-stage stall for dependent MDU instructions.
module mdu_ctrl
    import mdu_defs::*;
#(
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDU_op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        req,
    input  logic        D_MDU_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] E_MDU_out
);

    mdu_state_e       state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      shadow_hi, shadow_lo;
    logic             shadow_div0;
    logic [31:0]      res_hi, res_lo;
    logic             res_div0;
    logic             start;
    logic             commit;
    logic             mt_ok;

    mdu_arith u_arith (
        .op     (E_MDU_op),
        .a      (E_A),
        .b      (E_B),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .div0   (res_div0)
    );

    assign start  = is_start_op(E_MDU_op) && (state == ST_IDLE) && !req;
    assign commit = (state == ST_RUN) && (cnt == CNT_W'(1));
    assign mt_ok  = (state == ST_IDLE) && !req;
    assign busy   = (state == ST_RUN);
    assign stall  = D_MDU_use && (busy || start);

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (start)  state_n = ST_RUN;
            ST_RUN:  if (commit) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Results are latched at start so E_A/E_B may change while RUN; a
    // divide-by-zero still occupies DIV_LAT cycles but leaves HI/LO alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            shadow_hi   <= 32'd0;
            shadow_lo   <= 32'd0;
            shadow_div0 <= 1'b0;
            hi          <= 32'd0;
            lo          <= 32'd0;
        end else begin
            if (start) begin
                cnt         <= is_div_op(E_MDU_op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                shadow_hi   <= res_hi;
                shadow_lo   <= res_lo;
                shadow_div0 <= res_div0;
            end else if (state == ST_RUN) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (commit) begin
                if (!shadow_div0) begin
                    hi <= shadow_hi;
                    lo <= shadow_lo;
                end
            end else if (mt_ok) begin
                if (E_MDU_op == MDU_MTHI) hi <= E_A;
                if (E_MDU_op == MDU_MTLO) lo <= E_A;
            end
        end
    end

    always_comb begin
        E_MDU_out = 32'd0;
        case (E_MDU_op)
            MDU_MFHI: E_MDU_out = hi;
            MDU_MFLO: E_MDU_out = lo;
            default:  ;
        endcase
    end

endmodule
